// File: rtl/afifo_sched_pkg.sv
// rtl/afifo_sched_pkg.sv - shared types and constant helpers for the read-side WRR scheduler
//
// Purpose:
//   Holds the scheduler state encoding and the elaboration-time helpers used
//   to locate the last-of-packet flag and to size the queue index.
// Contents:
//   state_t    IDLE (arbitrating / no grant) or XFER (grant held)
//   last_bit   bit index of the last-of-packet flag inside a FIFO word
//   qid_width  queue-index width for a given queue count

package afifo_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    // The FIFO word carries the packet delimiter in its top bit.
    function automatic int last_bit(input int width_data);
        return width_data - 1;
    endfunction

    // Width needed to name one of n queues; a single queue still needs one bit.
    function automatic int qid_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/afifo_rd_wrr_sched_rr_pick.sv
// rtl/afifo_rd_wrr_sched_rr_pick.sv - combinational round-robin picker
//
// Purpose:
//   Finds the first asserted request strictly after the start pointer,
//   wrapping from N-1 back to 0. The pointer's own position is searched last,
//   which makes the pointer "the last queue served".
// Ports:
//   req      in   N       request vector
//   ptr      in   IDX_W   last served index; search starts at ptr+1
//   gnt_oh   out  N       one-hot winner (zero when nothing requests)
//   gnt_idx  out  IDX_W   encoded winner (zero when nothing requests)
//   any      out  1       at least one request present

module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt_oh,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    always_comb begin
        int idx;
        gnt_oh  = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        // Walk offsets 1..N so the current pointer is visited last; modulo
        // keeps this correct for non-power-of-two queue counts.
        for (int off = 1; off <= N; off++) begin
            idx = (int'(ptr) + off) % N;
            if (!any && req[idx]) begin
                any         = 1'b1;
                gnt_oh[idx] = 1'b1;
                gnt_idx     = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/afifo_rd_wrr_sched.sv
// rtl/afifo_rd_wrr_sched.sv - read-side weighted round-robin packet scheduler for show-ahead FIFOs
//
// Purpose:
//   Drains whole packets from one of N_QUEUE show-ahead async FIFOs at a time
//   onto a single valid/ready stream. Each grant is bounded by a per-queue word
//   quantum that is only checked at packet ends, so packets are never split or
//   interleaved. Runs entirely in the FIFO read clock domain.
// Ports:
//   rdclock     in   1                    scheduler / FIFO read clock
//   rd_rst      in   1                    asynchronous active-high reset
//   q_empty     in   N_QUEUE              FIFO empty flags
//   q_rdata     in   N_QUEUE*WIDTH_DATA   FIFO head words, queue i at [i*WIDTH_DATA +: WIDTH_DATA]
//   q_ren       out  N_QUEUE              FIFO pop strobes, one-hot or zero
//   q_enable    in   N_QUEUE              per-queue eligibility mask
//   cfg_weight  in   N_QUEUE*WEIGHT_W     per-queue word quantum (0 behaves as 1)
//   out_valid   out  1                    output word valid
//   out_ready   in   1                    downstream accept
//   out_data    out  WIDTH_DATA-1         payload of the granted head word
//   out_last    out  1                    last-of-packet flag of the granted head word
//   out_qid     out  QID_W                granted queue index
//   busy        out  1                    a grant is held

module afifo_rd_wrr_sched
    import afifo_sched_pkg::*;
#(
    parameter int N_QUEUE    = 4,
    parameter int WIDTH_DATA = 36,
    parameter int WEIGHT_W   = 8,
    parameter int QID_W      = 2
) (
    input  logic                          rdclock,
    input  logic                          rd_rst,
    input  logic [N_QUEUE-1:0]            q_empty,
    input  logic [N_QUEUE*WIDTH_DATA-1:0] q_rdata,
    output logic [N_QUEUE-1:0]            q_ren,
    input  logic [N_QUEUE-1:0]            q_enable,
    input  logic [N_QUEUE*WEIGHT_W-1:0]   cfg_weight,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH_DATA-2:0]         out_data,
    output logic                          out_last,
    output logic [QID_W-1:0]              out_qid,
    output logic                          busy
);

    localparam int                  LAST    = last_bit(WIDTH_DATA);
    localparam logic [WEIGHT_W-1:0] CNT_MAX = '1;

    generate
        if (QID_W != qid_width(N_QUEUE)) begin : g_bad_qid_w
            $error("afifo_rd_wrr_sched: QID_W must equal clog2(N_QUEUE)");
        end
    endgenerate

    state_t               state;
    state_t               state_nxt;
    logic [QID_W-1:0]     gnt;
    logic [N_QUEUE-1:0]   gnt_oh;
    logic [QID_W-1:0]     rr_ptr;
    logic [WEIGHT_W-1:0]  word_cnt;
    logic                 at_boundary;

    logic [N_QUEUE-1:0]   elig;
    logic [N_QUEUE-1:0]   pick_oh;
    logic [QID_W-1:0]     pick_idx;
    logic                 pick_any;

    logic [WIDTH_DATA-1:0] head;
    logic                  head_last;
    logic                  gnt_empty;
    logic                  gnt_enable;
    logic [WEIGHT_W-1:0]   gnt_weight;
    logic [WEIGHT_W-1:0]   eff_weight;
    logic [WEIGHT_W:0]     cnt_inc;
    logic                  quota_hit;
    logic                  beat;
    logic                  pkt_release;
    logic                  early_release;
    logic                  release_gnt;

    // Arbitration: only queues with a word waiting and enabled compete.
    assign elig = ~q_empty & q_enable;

    rr_pick #(
        .N     (N_QUEUE),
        .IDX_W (QID_W)
    ) u_rr_pick (
        .req     (elig),
        .ptr     (rr_ptr),
        .gnt_oh  (pick_oh),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    // Granted-queue view: head word, flags and weight of the held queue.
    // A compare loop keeps out-of-range indices harmless for odd N_QUEUE.
    always_comb begin
        head       = '0;
        gnt_empty  = 1'b1;
        gnt_enable = 1'b0;
        gnt_weight = '0;
        for (int i = 0; i < N_QUEUE; i++) begin
            if (gnt == QID_W'(i)) begin
                head       = q_rdata[i*WIDTH_DATA +: WIDTH_DATA];
                gnt_empty  = q_empty[i];
                gnt_enable = q_enable[i];
                gnt_weight = cfg_weight[i*WEIGHT_W +: WEIGHT_W];
            end
        end
    end

    assign head_last  = head[LAST];
    assign eff_weight = (gnt_weight == '0) ? {{(WEIGHT_W-1){1'b0}}, 1'b1} : gnt_weight;
    // One extra bit so a saturated counter plus this beat never wraps.
    assign cnt_inc    = {1'b0, word_cnt} + {{WEIGHT_W{1'b0}}, 1'b1};
    assign quota_hit  = cnt_inc >= {1'b0, eff_weight};

    assign beat          = (state == XFER) && !gnt_empty && out_ready;
    // Quantum and enable are only looked at on a packet's final word.
    assign pkt_release   = beat && head_last && (quota_hit || !gnt_enable);
    // Between packets with nothing queued: give the slot back rather than wait.
    assign early_release = (state == XFER) && at_boundary && gnt_empty;
    assign release_gnt   = pkt_release || early_release;

    // FSM state register
    always_ff @(posedge rdclock or posedge rd_rst) begin
        if (rd_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_any)    state_nxt = XFER;
            XFER:    if (release_gnt) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant, quantum counter, packet-boundary tracking and round-robin pointer
    always_ff @(posedge rdclock or posedge rd_rst) begin
        if (rd_rst) begin
            gnt         <= '0;
            gnt_oh      <= '0;
            rr_ptr      <= QID_W'(N_QUEUE - 1);
            word_cnt    <= '0;
            at_boundary <= 1'b1;
        end else begin
            if (state == IDLE && pick_any) begin
                gnt      <= pick_idx;
                gnt_oh   <= pick_oh;
                word_cnt <= '0;
            end
            if (beat) begin
                if (word_cnt != CNT_MAX) begin
                    word_cnt <= word_cnt + 1'b1;
                end
                at_boundary <= head_last;
            end
            if (release_gnt) begin
                rr_ptr <= gnt;
            end
        end
    end

    // FSM outputs; the head is muxed straight through so back-pressure
    // simply leaves the FIFO head (and therefore the output) unchanged.
    always_comb begin
        out_valid = 1'b0;
        busy      = 1'b0;
        q_ren     = '0;
        out_data  = head[WIDTH_DATA-2:0];
        out_last  = head_last;
        out_qid   = gnt;
        if (state == XFER) begin
            busy      = 1'b1;
            out_valid = !gnt_empty;
            if (beat) begin
                q_ren = gnt_oh;
            end
        end
    end

endmodule
